inst_fetch_bus_if: RTL

- Responder side of the PC-generator fetch interface.
- Accepts the fetch address (pc, 32 bit) and chip-enable from the PC stage.
- Performs a single-outstanding request/acknowledge read on the instruction memory bus, and returns the instruction word to the IF/ID register.
- Asserts a stall request to the pipeline controller while a fetch is in flight. Sits between the PC stage, the ctrl block and the instruction memory bus.

---
 rtl/inst_fetch_bus_if_pkg.sv | 24 ++
 rtl/inst_fetch_bus_if_if.sv | 33 +++
 rtl/inst_fetch_bus_if.sv | 107 ++++++++++
 3 files changed

// File: rtl/inst_fetch_bus_if_pkg.sv
// Shared definitions for the instruction-fetch bus responder.
// Holds the fetch FSM state encoding, the legacy pipeline constants used
// throughout the core, and the default NOP instruction word.
package inst_fetch_bus_if_pkg;

    // Legacy pipeline constants
    localparam logic        RstEnable   = 1'b1;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        NoStop      = 1'b0;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam int          InstAddrBus = 32;   // fetch address width
    localparam int          InstBus     = 32;   // instruction word width

    // Word handed to IF/ID whenever no valid fetch data is available
    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        HOLD  = 2'b10,
        DRAIN = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_bus_if_if.sv
// Bundle of the fetch-side and memory-side signals of the fetch responder.
//   cpu_ce_i / cpu_addr_i : fetch enable and pc from the PC stage
//   stall_i / flush_i     : pipeline control from ctrl
//   mem_ack_i / mem_data_i: memory acknowledge and read data
//   mem_req_o / mem_addr_o: memory read request and address
//   cpu_inst_o            : instruction to IF/ID
//   stallreq_o            : stall request to ctrl
// slave  = the fetch responder; master = everything around it.
interface inst_fetch_bus_if_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_ce_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [5:0]        stall_i;
    logic              flush_i;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] cpu_inst_o;
    logic              stallreq_o;

    modport slave (
        input  cpu_ce_i, cpu_addr_i, stall_i, flush_i, mem_ack_i, mem_data_i,
        output mem_req_o, mem_addr_o, cpu_inst_o, stallreq_o
    );

    modport master (
        output cpu_ce_i, cpu_addr_i, stall_i, flush_i, mem_ack_i, mem_data_i,
        input  mem_req_o, mem_addr_o, cpu_inst_o, stallreq_o
    );
endinterface

// File: rtl/inst_fetch_bus_if.sv
// Instruction-fetch bus responder.
// Takes pc/chip-enable from the PC stage, issues one outstanding
// request/acknowledge read on the instruction memory bus, and hands the
// word to IF/ID. Raises stallreq_o while a fetch is in flight.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of inst_fetch_bus_if_if (see interface header)
module inst_fetch_bus_if #(
    parameter int                ADDR_W   = inst_fetch_bus_if_pkg::InstAddrBus,
    parameter int                DATA_W   = inst_fetch_bus_if_pkg::InstBus,
    parameter logic [DATA_W-1:0] NOP_WORD = inst_fetch_bus_if_pkg::NOP_WORD
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_bus_if_if.slave  bus
);
    import inst_fetch_bus_if_pkg::*;

    fetch_state_t      state_q,    state_d;
    logic              mem_req_q,  mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] rd_buf_q,   rd_buf_d;
    logic [DATA_W-1:0] cpu_inst;
    logic              stallreq;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        rd_buf_d   = rd_buf_q;
        cpu_inst   = NOP_WORD;
        stallreq   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cpu_ce_i == ChipEnable && !bus.flush_i) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = bus.cpu_addr_i;
                    state_d    = BUSY;
                    stallreq   = 1'b1;
                end
            end
            BUSY: begin
                if (bus.mem_ack_i) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    // Flush beats a coincident ack: the word is never shown.
                    if (!bus.flush_i) begin
                        cpu_inst = bus.mem_data_i;
                        rd_buf_d = bus.mem_data_i;
                        if (bus.stall_i != 6'b0)
                            state_d = HOLD;
                    end
                end else begin
                    // Request cannot be withdrawn; a flush must wait out the ack.
                    stallreq = 1'b1;
                    if (bus.flush_i)
                        state_d = DRAIN;
                end
            end
            HOLD: begin
                if (bus.flush_i) begin
                    rd_buf_d = ZeroWord[DATA_W-1:0];
                    state_d  = IDLE;
                end else begin
                    cpu_inst = rd_buf_q;
                    if (bus.stall_i == 6'b0)
                        state_d = IDLE;
                end
            end
            DRAIN: begin
                stallreq = 1'b1;
                if (bus.mem_ack_i) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst == RstEnable) begin
            cpu_inst = NOP_WORD;
            stallreq = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            rd_buf_q   <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            rd_buf_q   <= rd_buf_d;
        end
    end

    assign bus.mem_req_o  = mem_req_q;
    assign bus.mem_addr_o = mem_addr_q;
    assign bus.cpu_inst_o = cpu_inst;
    assign bus.stallreq_o = stallreq;

endmodule
